link_rx_packer: RTL and testbench
=================================

# link_rx_packer

Receive-side byte packer and word buffer downstream of the link `slave`. Each byte accepted over the req/ack link is handed to this block with a one-cycle strobe. The block packs four bytes into a 32-bit word and buffers completed words in a small FIFO. Words leave on a valid/ready stream toward the consumer. When the FIFO fills, `in_ready` deasserts so the slave can hold off `ack`.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO depth in 32-bit words. Must be a power of two, ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: synchronous, active-high reset.
- `in_valid`  input  1: byte strobe from slave.
- `in_data`  input  8: byte payload.
- `in_ready`  output  1: block can accept a byte this cycle.
- `flush`  input  1: discard the partial word and empty the FIFO.
- `out_valid`  output  1: FIFO head word available.
- `out_data`  output  32: FIFO head word.
- `out_chk`  output  8: XOR checksum of head word's bytes (see Configuration).
- `out_ready`  input  1: consumer accepts head word.
- `level`  output  $clog2(DEPTH)+1: number of words stored.
- `drop_err`  output  1: sticky flag; a byte was offered while `in_ready`=0.

## Operation
- **Accept:** a byte is accepted when `in_valid && in_ready` at a rising edge.
- **Packer state:** `byte_idx` (2 bits, 0..3) plus a 24-bit partial register.
- **Byte placement:** byte k of a word lands in bits [8k+7:8k]. The first byte goes to the LSBs (little-endian).
- **Word completion:** on the 4th accepted byte (`byte_idx`=3), the full word {in_data, partial} is pushed into the FIFO and `byte_idx` wraps to 0.
- **Packer states:** `IDLE` (idx 0), `B1`, `B2`, `B3`.
  - Each accepted byte advances one state.
  - `B3` → `IDLE` with a push.
  - `flush` → `IDLE` from any state.
- **in_ready:** `!(byte_idx==3 && level==DEPTH)`. It is computed from registered state only; there is no combinational path from `out_ready`.
- **Pop:** `out_valid && out_ready` pops the head. `out_valid` = `(level != 0)`. The output is show-ahead, and `out_data`/`out_chk` are stable while `out_valid` is high and not popped.
- **Simultaneous push and pop:** `level` is unchanged and both take effect.
- **Full FIFO:**
  - Bytes 0–2 of the next word are still accepted.
  - Byte 3 stalls until a pop has registered.
- **Overflow:** `in_valid && !in_ready` sets `drop_err`. The byte is ignored and state is unchanged. `drop_err` clears only on `rst`.
- **Pointers:** read/write pointers are $clog2(DEPTH) bits and wrap naturally. `level` is a separate up/down counter.
- **flush:**
  - In the same edge, clears `byte_idx`, the partial register, the pointers and `level`.
  - Any byte or pop presented that cycle is ignored.
  - Does not clear `drop_err`.
- **rst:** as `flush`, and also clears `drop_err`. A partial word in progress is lost.

## Timing
- **Reset values:**
  - `in_ready`=1
  - `out_valid`=0
  - `out_data`=0 (don't-care contents masked to 0)
  - `out_chk`=0
  - `level`=0
  - `drop_err`=0
- **Latency:** 4th byte accepted at edge T → `out_valid`=1 and the word on `out_data` after edge T, i.e. visible in cycle T+1. There is no empty-FIFO bypass.
- **Level updates:** `level` updates one cycle after the push/pop edge, as do `out_valid` and `in_ready`.
- **Throughput:** one byte per cycle in; one word per cycle out.
- **Full with stalled byte 3:** a pop at edge P raises `in_ready` after P, so byte 3 can be accepted at P+1.

## Configuration
- Macro `LINK_RX_CHKSUM_EN`.
- **Defined:**
  - A running XOR of accepted bytes is kept per word and stored as an 8-bit checksum alongside the word in the FIFO, 40 bits per entry.
  - `out_chk` = in_data0^in_data1^in_data2^in_data3 of the head word.
  - The running XOR is cleared on word completion, `flush` and `rst`.
- **Undefined:**
  - FIFO entries are 32 bits.
  - `out_chk` is tied to 8'h00.
  - All other behaviour is identical.

## Test plan
- **Basic pack:** reset, bytes 0x11,0x22,0x33,0x44 on consecutive cycles, `out_ready`=1 → `out_data`=0x44332211 the cycle after the 4th byte, `level` 1 then 0. With the macro, `out_chk`=0x44.
- **Fill and back-pressure:** DEPTH=4, `out_ready`=0, stream 20 bytes.
  - `in_ready` drops after byte 19 is accepted.
  - `level`=4; byte 20 is held off.
  - Raising `out_ready` for one cycle → byte 20 accepted the following cycle.
- **Simultaneous push/pop at level 2:** pushes and pops happen on the same edge → `level` stays 2 and word order is preserved across a pointer wrap (12 words total).
- **Overflow:** assert `in_valid` while `in_ready`=0 → `drop_err`=1, no state change. `flush` leaves it set; `rst` clears it.
- **Mid-word flush:** 2 bytes then `flush`, then 0xA0..0xA3 → `out_data`=0xA3A2A1A0 and no stale bytes.
- **Reset mid-operation:** 3 bytes plus 2 stored words, then `rst` → all outputs at reset values next cycle; the next 4 bytes form a clean word.

Source files
------------

// File: rtl/link_rx_packer.sv
// link_rx_packer
//   Receive-side byte packer and word FIFO. Bytes strobed in from the link slave are packed
//   little-endian into 32-bit words (first byte in bits [7:0]). Completed words are buffered
//   in a DEPTH-entry FIFO and leave on a show-ahead valid/ready stream.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid, in_data     byte strobe and payload from the slave
//   in_ready              a byte can be accepted this cycle (registered state only)
//   flush                 drop the partial word and empty the FIFO
//   out_valid, out_data   FIFO head word (data masked to 0 when empty)
//   out_chk               XOR of the head word's four bytes, or 0 when the checksum is off
//   out_ready             consumer pops the head word
//   level                 words currently stored
//   drop_err              sticky: a byte was offered while in_ready was low
//
// Build option
//   LINK_RX_CHKSUM_EN     store an 8-bit running XOR with each word (40-bit entries)

module link_rx_packer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   output logic                     in_ready,
   input  logic                     flush,
   output logic                     out_valid,
   output logic [31:0]              out_data,
   output logic [7:0]               out_chk,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     drop_err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;
`ifdef LINK_RX_CHKSUM_EN
   localparam int unsigned EW = 40;
`else
   localparam int unsigned EW = 32;
`endif

   // Packer state doubles as the byte index within the current word.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StB1   = 2'd1,
      StB2   = 2'd2,
      StB3   = 2'd3
   } pack_state_e;

   pack_state_e       state_q, state_d;
   logic [23:0]       partial_q, partial_d;
   logic [PW-1:0]     wptr_q, rptr_q;
   logic [LW-1:0]     level_q;
   logic              drop_q;
   logic [EW-1:0]     mem [DEPTH];
   logic [EW-1:0]     push_entry;
   logic [EW-1:0]     head_entry;

   logic              accept;
   logic              push;
   logic              pop;

`ifdef LINK_RX_CHKSUM_EN
   logic [7:0]        chk_q, chk_d;
`endif

   // Only byte 3 can stall: bytes 0-2 sit in the partial register, not the FIFO.
   assign in_ready  = !(state_q == StIdle + 2'd3 && level_q == LW'(DEPTH));
   assign out_valid = (level_q != '0);
   assign level     = level_q;
   assign drop_err  = drop_q;

   assign accept = in_valid && in_ready && !flush;
   assign push   = accept && (state_q == StB3);
   assign pop    = out_valid && out_ready && !flush;

   assign head_entry = mem[rptr_q];
   assign out_data   = out_valid ? head_entry[31:0] : 32'h0;

`ifdef LINK_RX_CHKSUM_EN
   assign push_entry = {chk_q ^ in_data, in_data, partial_q};
   assign out_chk    = out_valid ? head_entry[39:32] : 8'h00;

   always_comb begin
      chk_d = chk_q;
      if (flush || push) begin
         chk_d = 8'h00;
      end else if (accept) begin
         chk_d = chk_q ^ in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chk_q <= 8'h00;
      end else begin
         chk_q <= chk_d;
      end
   end
`else
   assign push_entry = {in_data, partial_q};
   assign out_chk    = 8'h00;
`endif

   // Packer next-state.
   always_comb begin
      state_d   = state_q;
      partial_d = partial_q;
      if (flush) begin
         state_d   = StIdle;
         partial_d = '0;
      end else if (accept) begin
         unique case (state_q)
            StIdle: begin
               partial_d[7:0] = in_data;
               state_d        = StB1;
            end
            StB1: begin
               partial_d[15:8] = in_data;
               state_d         = StB2;
            end
            StB2: begin
               partial_d[23:16] = in_data;
               state_d          = StB3;
            end
            StB3: begin
               partial_d = '0;
               state_d   = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         partial_q <= '0;
      end else begin
         state_q   <= state_d;
         partial_q <= partial_d;
      end
   end

   // FIFO pointers, level and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         if (in_valid && !in_ready) begin
            drop_q <= 1'b1;
         end
         if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
         end else begin
            if (push) begin
               wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
               rptr_q <= rptr_q + PW'(1);
            end
            if (push && !pop) begin
               level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
               level_q <= level_q - LW'(1);
            end
         end
      end
   end

   // Storage is not reset; reads are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wptr_q] <= push_entry;
      end
   end

endmodule

// File: tb/tb_link_rx_packer.sv
module tb_link_rx_packer;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        flush;
   logic        out_valid;
   logic [31:0] out_data;
   logic [7:0]  out_chk;
   logic        out_ready;
   logic [$clog2(DEPTH):0] level;
   logic        drop_err;

   int checks   = 0;
   int failures = 0;

   // Reference model: bytes of the word in progress, stored words, sticky drop flag.
   logic [7:0]  pb[$];
   logic [31:0] wq[$];
   bit          m_drop;

   always #5 clk = ~clk;

   link_rx_packer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_chk   (out_chk),
      .out_ready (out_ready),
      .level     (level),
      .drop_err  (drop_err)
   );

   function automatic bit model_ready();
      return !(pb.size() == 3 && wq.size() == DEPTH);
   endfunction

   function automatic void model_step(bit v, logic [7:0] d, bit f, bit r, bit rs);
      bit rdy;
      rdy = model_ready();
      if (rs) begin
         pb.delete();
         wq.delete();
         m_drop = 1'b0;
         return;
      end
      if (v && !rdy) m_drop = 1'b1;
      if (f) begin
         pb.delete();
         wq.delete();
         return;
      end
      if (r && wq.size() != 0) void'(wq.pop_front());
      if (v && rdy) begin
         pb.push_back(d);
         if (pb.size() == 4) begin
            wq.push_back({pb[3], pb[2], pb[1], pb[0]});
            pb.delete();
         end
      end
   endfunction

   function automatic logic [50:0] exp_vec();
      logic [31:0] w;
      logic [7:0]  c;
      w = (wq.size() != 0) ? wq[0] : 32'h0;
`ifdef LINK_RX_CHKSUM_EN
      c = w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
`else
      c = 8'h00;
`endif
      return {model_ready(), wq.size() != 0, w, c, 8'(wq.size()), m_drop};
   endfunction

   function automatic logic [50:0] dut_vec();
      return {in_ready, out_valid, out_data, out_chk, 8'(level), drop_err};
   endfunction

   // Apply one cycle of inputs, advance the model at the edge, return at the falling edge.
   task automatic drive(bit v, logic [7:0] d, bit f, bit r, bit rs);
      in_valid  = v;
      in_data   = d;
      flush     = f;
      out_ready = r;
      rst       = rs;
      @(posedge clk);
      model_step(v, d, f, r, rs);
      @(negedge clk);
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b0;
   endtask

   task automatic test_reset();
      drive(0, 8'h00, 0, 0, 1);
      drive(0, 8'h00, 0, 0, 1);
      if (dut_vec() !== {1'b1, 1'b0, 32'h0, 8'h00, 8'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset_values got=%h exp=%h", dut_vec(),
                  {1'b1, 1'b0, 32'h0, 8'h00, 8'd0, 1'b0});
      end
      checks++;
   endtask

   task automatic test_basic();
      logic [7:0] b [4];
      b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         drive(1, b[i], 0, 0, 0);
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL basic byte=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
         end
         checks++;
      end
      if (out_data !== 32'h44332211 || level !== 3'd1) begin
         failures++;
         $display("FAIL basic_word got=%h/%0d exp=44332211/1", out_data, level);
      end
      checks++;
      drive(0, 8'h00, 0, 1, 0);
      if (dut_vec() !== exp_vec() || level !== 3'd0) begin
         failures++;
         $display("FAIL basic_pop got=%h exp=%h", dut_vec(), exp_vec());
      end
      checks++;
   endtask

   task automatic test_fill();
      drive(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 19; i++) begin
         drive(1, 8'(8'h50 + i), 0, 0, 0);
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL fill byte=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
         end
         checks++;
      end
      if (in_ready !== 1'b0 || level !== 3'd4) begin
         failures++;
         $display("FAIL fill_full got=rdy%0b/lvl%0d exp=rdy0/lvl4", in_ready, level);
      end
      checks++;
      drive(0, 8'h00, 0, 1, 0);
      if (in_ready !== 1'b1 || level !== 3'd3 || dut_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL fill_pop got=%h exp=%h", dut_vec(), exp_vec());
      end
      checks++;
      drive(1, 8'h63, 0, 0, 0);
      if (level !== 3'd4 || in_ready !== 1'b1 || dut_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL fill_byte20 got=%h exp=%h", dut_vec(), exp_vec());
      end
      checks++;
   endtask

   task automatic test_pushpop();
      drive(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 8; i++) drive(1, 8'($urandom), 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         drive(1, 8'($urandom), 0, (i % 4) == 3, 0);
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL pushpop cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
         end
         checks++;
      end
      if (level !== 3'd2) begin
         failures++;
         $display("FAIL pushpop_level got=%0d exp=2", level);
      end
      checks++;
      for (int i = 0; i < 3; i++) begin
         drive(0, 8'h00, 0, 1, 0);
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL pushpop_drain cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
         end
         checks++;
      end
   endtask

   task automatic test_overflow();
      drive(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 19; i++) drive(1, 8'(i), 0, 0, 0);
      drive(1, 8'hEE, 0, 0, 0);
      if (drop_err !== 1'b1 || level !== 3'd4 || dut_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL overflow got=%h exp=%h", dut_vec(), exp_vec());
      end
      checks++;
      drive(0, 8'h00, 1, 0, 0);
      if (drop_err !== 1'b1 || level !== 3'd0 || dut_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL overflow_flush got=%h exp=%h", dut_vec(), exp_vec());
      end
      checks++;
      drive(0, 8'h00, 0, 0, 1);
      if (drop_err !== 1'b0) begin
         failures++;
         $display("FAIL overflow_rst got=%0b exp=0", drop_err);
      end
      checks++;
   endtask

   task automatic test_flush_mid();
      drive(1, 8'h77, 0, 0, 0);
      drive(1, 8'h88, 0, 0, 0);
      drive(0, 8'h00, 1, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 8'(8'hA0 + i), 0, 0, 0);
      if (out_data !== 32'hA3A2A1A0 || dut_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL flush_mid got=%h exp=a3a2a1a0", out_data);
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      drive(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 11; i++) drive(1, 8'($urandom), 0, 0, 0);
      drive(0, 8'h00, 0, 0, 1);
      if (dut_vec() !== {1'b1, 1'b0, 32'h0, 8'h00, 8'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset_mid got=%h", dut_vec());
      end
      checks++;
      for (int i = 0; i < 4; i++) drive(1, 8'(8'hC0 + i), 0, 0, 0);
      if (out_data !== 32'hC3C2C1C0 || level !== 3'd1) begin
         failures++;
         $display("FAIL reset_mid_word got=%h/%0d exp=c3c2c1c0/1", out_data, level);
      end
      checks++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 63) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
         end
         checks++;
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      flush     = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_fill();
      test_pushpop();
      test_overflow();
      test_flush_mid();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
